// File: rtl/scalar_registers.sv
// Scalar register file: 2**ADDR_WIDTH x DATA_WIDTH, one synchronous write port,
// two combinational read ports. Register 0 is ordinary storage.
module scalar_registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  WriteEn,
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] Rs1,
  input  logic [ADDR_WIDTH-1:0] Rs2,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] InputData,
  output logic [DATA_WIDTH-1:0] Rout1,
  output logic [DATA_WIDTH-1:0] Rout2,
  input  logic                  rst
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];

  // Reset wins over a write on the same edge; reads see stored contents only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (WriteEn) begin
      regs[rd] <= InputData;
    end
  end

  assign Rout1 = regs[Rs1];
  assign Rout2 = regs[Rs2];

endmodule

// File: tb/tb_scalar_registers.sv
// Directed bench for scalar_registers: vector table plus hand-written
// sequences for read-during-write, between-edge input changes and reset.
module tb_scalar_registers;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WriteEn = 1'b0;
  logic [4:0]  Rs1 = '0;
  logic [4:0]  Rs2 = '0;
  logic [4:0]  rd = '0;
  logic [31:0] InputData = '0;
  logic [31:0] Rout1;
  logic [31:0] Rout2;

  int errors = 0;
  int checks = 0;

  scalar_registers #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .WriteEn   (WriteEn),
    .clk       (clk),
    .Rs1       (Rs1),
    .Rs2       (Rs2),
    .rd        (rd),
    .InputData (InputData),
    .Rout1     (Rout1),
    .Rout2     (Rout2),
    .rst       (rst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] wa, input logic [31:0] d);
    rst = r; WriteEn = we; Rs1 = a1; Rs2 = a2; rd = wa; InputData = d;
  endtask

  initial begin
    // Expected outputs are sampled after the edge with the same read addresses.
    vecs[0] = '{"reset_read",     1, 0,  0, 31,  0, 32'h0,        32'h0,        32'h0};
    vecs[1] = '{"write_r0",       0, 1,  0,  2,  0, 32'd100,      32'd100,      32'h0};
    vecs[2] = '{"write_r2",       0, 1,  0,  2,  2, 32'd100,      32'd100,      32'd100};
    vecs[3] = '{"write_disabled", 0, 0,  5,  2,  5, 32'hDEADBEEF, 32'h0,        32'd100};
    vecs[4] = '{"write_r7",       0, 1,  7,  6,  7, 32'd3,        32'd3,        32'h0};
    vecs[5] = '{"write_r31",      0, 1, 31, 31, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6] = '{"write_r1",       0, 1,  1,  0,  1, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'd100};
    vecs[7] = '{"overwrite_r0",   0, 1,  0,  2,  0, 32'h12345678, 32'h12345678, 32'd100};
    vecs[8] = '{"reset_priority", 1, 1,  4, 31,  4, 32'd55,       32'h0,        32'h0};
    vecs[9] = '{"after_reset",    0, 0,  7,  1,  3, 32'h0,        32'h0,        32'h0};

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].rst, vecs[i].we, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].data);
      @(posedge clk);
      @(negedge clk);
      check({vecs[i].name, ".Rout1"}, Rout1, vecs[i].exp1);
      check({vecs[i].name, ".Rout2"}, Rout2, vecs[i].exp2);
    end

    // Read-during-write: old value before the edge, new value after.
    drive(0, 1, 7, 7, 7, 32'd3);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 7, 7, 7, 32'd9);
    #1;
    check("rdw_before.Rout1", Rout1, 32'd3);
    check("rdw_before.Rout2", Rout2, 32'd3);
    @(posedge clk);
    #1;
    check("rdw_after.Rout1", Rout1, 32'd9);
    check("rdw_after.Rout2", Rout2, 32'd9);

    // Inputs change between edges: only values present at the edge matter.
    @(negedge clk);
    drive(0, 1, 10, 11, 10, 32'hCAFE0001);
    #2;
    WriteEn = 1'b0;
    @(posedge clk);
    #1;
    check("glitch_we.r10", Rout1, 32'h0);
    @(negedge clk);
    drive(0, 1, 11, 10, 11, 32'd1);
    #2;
    InputData = 32'd2;
    @(posedge clk);
    #1;
    check("late_data.r11", Rout1, 32'd2);
    check("late_data.r10", Rout2, 32'h0);

    // Mid-operation reset: contents still readable until the next edge.
    @(negedge clk);
    drive(1, 0, 11, 7, 0, 32'h0);
    #1;
    check("rst_pending.r11", Rout1, 32'd2);
    check("rst_pending.r7", Rout2, 32'd9);
    @(posedge clk);
    #1;
    check("rst_done.r11", Rout1, 32'h0);
    check("rst_done.r7", Rout2, 32'h0);

    // Fill every register with a distinct value, then read all back on both ports.
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 5'd0, 5'd0, 5'(i), 32'h1000_0000 + 32'(i) * 32'd3 + 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    WriteEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rs1 = 5'(i);
      Rs2 = 5'(31 - i);
      #1;
      check($sformatf("fill.r%0d", i), Rout1, 32'h1000_0000 + 32'(i) * 32'd3 + 32'd1);
      check($sformatf("fill.r%0d", 31 - i), Rout2, 32'h1000_0000 + 32'(31 - i) * 32'd3 + 32'd1);
    end

    // Reset clears every register.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Rs1 = 5'(i);
      Rs2 = 5'(i);
      #1;
      check($sformatf("cleared.r%0d", i), Rout1, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scalar_registers.md
SCALAR_REGISTERS -- requirements
Module: scalar_registers

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register and data-port width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, giving the address width (2**ADDR_WIDTH registers, 32 by default).
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port WriteEn  input  1  write enable for the write port.
REQ-006 Port Rs1  input  ADDR_WIDTH  read address, port 1.
REQ-007 Port Rs2  input  ADDR_WIDTH  read address, port 2.
REQ-008 Port rd  input  ADDR_WIDTH  write (destination) address.
REQ-009 Port InputData  input  DATA_WIDTH  write data.
REQ-010 Port Rout1  output  DATA_WIDTH  read data for Rs1.
REQ-011 Port Rout2  output  DATA_WIDTH  read data for Rs2.
REQ-012 The positional port order SHALL be WriteEn, clk, Rs1, Rs2, rd, InputData, Rout1, Rout2, rst, so existing positional instantiations connect unchanged.

Function
REQ-013 The block SHALL hold 2**ADDR_WIDTH general registers of DATA_WIDTH bits each; all registers, including register 0, are ordinary writable storage (no hardwired zero).
REQ-014 On a rising clk edge with rst=0 and WriteEn=1, register[rd] SHALL be loaded with InputData; no other register changes.
REQ-015 On a rising clk edge with WriteEn=0, no register SHALL change.
REQ-016 WriteEn, rd and InputData SHALL be sampled only at the rising edge; changes between edges have no effect on stored state.
REQ-017 Rout1 SHALL equal register[Rs1] and Rout2 SHALL equal register[Rs2] combinationally (zero-cycle read latency, no clock involvement).
REQ-018 A write SHALL become visible on Rout1/Rout2 immediately after the rising edge that performs it; before that edge the old value is read (no write-to-read bypass of InputData).
REQ-019 Rs1 and Rs2 SHALL be independent; both may address the same register, and either may equal rd, with no change to REQ-017/REQ-018 behaviour.
REQ-020 The block SHALL have no handshake, stall or error outputs; every address in range is valid.

Reset
REQ-021 On a rising clk edge with rst=1, every register SHALL be cleared to 0, so Rout1 and Rout2 read 0 for any address afterwards.
REQ-022 rst SHALL take priority over WriteEn; a write requested in a reset cycle is discarded.
REQ-023 Reset asserted mid-operation SHALL affect state only at the next rising edge; reads remain combinational of current contents until then.

Verification
REQ-024 Reset then read: rst=1 for one edge, then Rs1=0, Rs2=31 -> Rout1=0, Rout2=0.
REQ-025 Write register 0: WriteEn=1, rd=0, InputData=100, one rising edge, Rs1=0 -> Rout1=100 after the edge; Rs2=2 -> Rout2=0.
REQ-026 Write register 2: WriteEn=1, rd=2, InputData=100, one edge, Rs1=0, Rs2=2 -> Rout1=100, Rout2=100; other registers unchanged.
REQ-027 Write disabled: WriteEn=0, rd=5, InputData=0xDEADBEEF, edge -> Rs1=5 reads 0.
REQ-028 Read-during-write timing: Rs1=rd=7, register 7 holds 3, WriteEn=1, InputData=9 -> Rout1=3 before the edge, 9 after it.
REQ-029 Reset priority: rst=1 and WriteEn=1, rd=4, InputData=55 on the same edge -> register 4 reads 0 afterwards.
